// File: rtl/gfgt_rd_pkg.sv
// rtl/gfgt_rd_pkg.sv - shared constants and FSM state type for the frame-buffer read controller
package gfgt_rd_pkg;

  localparam int LANES     = 4;
  localparam int RD_AW_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/gfgt_rd_skid.sv
// rtl/gfgt_rd_skid.sv - two-entry in-order output buffer holding {last, data} read words
module gfgt_rd_skid
  import gfgt_rd_pkg::*;
#(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;

  // Storage and pointers; the caller's credit scheme guarantees no push when full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_occ != 2'd0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/gfgt_rd_ctrl.sv
// rtl/gfgt_rd_ctrl.sv - frame-buffer read controller with credit-limited wide reads (optional checksum: GFGT_RD_CSUM_EN)
module gfgt_rd_ctrl
  import gfgt_rd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_AW  = RD_AW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [RD_AW:0]            len,
  output logic                      busy,
  output logic                      done,
  output logic                      ram_we,
  output logic [RD_AW+1:0]          ram_a,
  input  logic [LANES*DATA_W-1:0]   ram_spo,
  output logic [LANES*DATA_W-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last
`ifdef GFGT_RD_CSUM_EN
  ,
  output logic [LANES*DATA_W-1:0]   csum
`endif
);

  localparam int WW = LANES * DATA_W;

  rd_state_t        r_state;
  rd_state_t        w_next;
  logic [RD_AW:0]   r_addr;
  logic [RD_AW:0]   r_len;
  logic             r_inflight;
  logic             r_inflight_last;
  logic [1:0]       w_occ;
  logic             w_pop;
  logic             w_issue;
  logic             w_credit_ok;
  logic             w_last_addr;
  logic             w_start_acc;
  logic [WW:0]      w_skid_data;

  assign w_pop       = m_valid & m_ready;
  // Buffer slots still free once the word in flight lands and this cycle's pop leaves
  assign w_credit_ok = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_last_addr = (r_addr == (r_len - {{RD_AW{1'b0}}, 1'b1}));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, read issue and status outputs
  always_comb begin
    w_next      = r_state;
    w_issue     = 1'b0;
    w_start_acc = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_start_acc = 1'b1;
          w_next      = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_last_addr) begin
            w_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_pop && m_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Frame length latch and wide-word address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_len  <= '0;
    end else if (w_start_acc) begin
      r_addr <= '0;
      r_len  <= len;
    end else if (w_issue) begin
      r_addr <= r_addr + {{RD_AW{1'b0}}, 1'b1};
    end
  end

  // Remember that a read is in flight so its data is captured one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_last_addr;
    end
  end

  gfgt_rd_skid #(
    .W (WW + 1)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, ram_spo}),
    .i_pop   (w_pop),
    .o_data  (w_skid_data),
    .o_valid (m_valid),
    .o_occ   (w_occ)
  );

  assign m_data = w_skid_data[WW-1:0];
  assign m_last = m_valid & w_skid_data[WW];
  assign ram_a  = {2'b00, r_addr[RD_AW-1:0]};
  assign ram_we = 1'b0;

`ifdef GFGT_RD_CSUM_EN
  logic [WW-1:0] r_csum;

  // Running XOR of delivered words, restarted for each accepted frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_start_acc) begin
      r_csum <= '0;
    end else if (w_pop) begin
      r_csum <= r_csum ^ m_data;
    end
  end

  assign csum = r_csum;
`endif

endmodule

// File: tb/tb_gfgt_rd_ctrl.sv
// tb/tb_gfgt_rd_ctrl.sv - scoreboard bench for gfgt_rd_ctrl (checksum checks under GFGT_RD_CSUM_EN)
module tb_gfgt_rd_ctrl;

  localparam int DATA_W = 32;
  localparam int RD_AW  = 10;
  localparam int WW     = 4 * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [RD_AW:0]    len;
  logic              busy;
  logic              done;
  logic              ram_we;
  logic [RD_AW+1:0]  ram_a;
  logic [WW-1:0]     ram_spo;
  logic [WW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
`ifdef GFGT_RD_CSUM_EN
  logic [WW-1:0]     csum;
`endif

  gfgt_rd_ctrl #(.DATA_W(DATA_W), .RD_AW(RD_AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .ram_we  (ram_we),
    .ram_a   (ram_a),
    .ram_spo (ram_spo),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last)
`ifdef GFGT_RD_CSUM_EN
    ,
    .csum    (csum)
`endif
  );

  always #5 clk = ~clk;

  // Frame buffer model: one-cycle synchronous read
  logic [WW-1:0] mem [1024];
  always @(posedge clk) ram_spo <= mem[ram_a[RD_AW-1:0]];

  typedef struct packed {
    logic [WW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks   = 0;
  int            n_errors   = 0;
  int            done_seen  = 0;
  int            frames_exp = 0;
  int            ready_mode = 0;
  logic [WW-1:0] exp_csum;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic fill_pattern(input int n);
    for (int k = 0; k < n; k++)
      mem[k] = {32'(4*k+3), 32'(4*k+2), 32'(4*k+1), 32'(4*k)};
  endtask

  // Expected frame = mem[0..n-1] in order, last flag on word n-1, csum = XOR of all
  task automatic start_frame(input int n);
    exp_t e;
    exp_csum = '0;
    for (int k = 0; k < n; k++) begin
      e.d = mem[k];
      e.l = (k == n - 1);
      exp_q.push_back(e);
      exp_csum ^= mem[k];
    end
    @(posedge clk); #1;
    start = 1'b1;
    len   = 11'(n);
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 11'($urandom_range(0, 2047));
  endtask

  task automatic wait_done(input int n);
    bit seen = 1'b0;
    for (int c = 0; c < 8 * n + 40 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
    frames_exp++;
`ifdef GFGT_RD_CSUM_EN
    chk("csum_at_done", csum, exp_csum);
    @(negedge clk);
    chk("csum_hold", csum, exp_csum);
`endif
  endtask

  // Downstream ready pattern: always, random, or 1,0,0 repeating
  initial begin
    int cyc = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (cyc % 3 == 1);
      endcase
    end
  end

  // Monitor: scoreboard pops, hold-while-stalled, done bookkeeping, static outputs
  initial begin
    exp_t          e;
    bit            prev_stall = 1'b0;
    logic [WW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      chk("ram_we_zero", ram_we, 1'b0);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("ram_a_upper", ram_a[RD_AW+1:RD_AW], 2'b00);
        if (prev_stall)
          chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
        if (m_valid && m_ready) begin
          chk("word_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word_data", m_data, e.d);
            chk("word_last", m_last, e.l);
          end
        end
        if (done) begin
          done_seen++;
          chk("done_queue_empty", exp_q.size(), 0);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  initial begin
    int n;
    for (int k = 0; k < 1024; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
    rst   = 1'b1;
    start = 1'b0;
    len   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_ram_a", ram_a, '0);
`ifdef GFGT_RD_CSUM_EN
    chk("rst_csum", csum, '0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // len=4 cycle-exact timeline with m_ready high
    ready_mode = 0;
    fill_pattern(4);
    start_frame(4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 4) chk($sformatf("t%0d_ram_a", c), ram_a, 12'(c - 1));
      chk($sformatf("t%0d_m_valid", c), m_valid, (c >= 3 && c <= 6));
      chk($sformatf("t%0d_m_last", c), m_last, (c == 6));
      chk($sformatf("t%0d_done", c), done, (c == 7));
      chk($sformatf("t%0d_busy", c), busy, (c <= 7));
    end
    frames_exp++;

    // Lane order: words {3,2,1,0} then {7,6,5,4}
    fill_pattern(2);
    start_frame(2);
    wait_done(2);

    // Throttled downstream, 1,0,0 ready pattern
    ready_mode = 2;
    fill_random(8);
    start_frame(8);
    wait_done(8);

    // Empty frame: done in t+1 with busy, no words
    ready_mode = 0;
    start_frame(0);
    @(negedge clk);
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b1);
    @(negedge clk);
    chk("len0_done_off", done, 1'b0);
    chk("len0_busy_off", busy, 1'b0);
    frames_exp++;

    // Random lengths with random backpressure
    ready_mode = 1;
    repeat (6) begin
      n = $urandom_range(1, 24);
      fill_random(n);
      start_frame(n);
      wait_done(n);
    end

    // Full buffer: 1024 words, last address 1023
    fill_random(1024);
    start_frame(1024);
    wait_done(1024);

    // start pulsed mid-frame must be ignored
    fill_random(10);
    start_frame(10);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    len   = 11'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10);
    repeat (10) @(negedge clk);

    // Reset mid-frame: outputs clear, no done
    fill_random(40);
    start_frame(40);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_done", done, 1'b0);
    end

`ifdef GFGT_RD_CSUM_EN
    chk("midrst_csum", csum, '0);
    ready_mode = 0;
    mem[0] = 128'h0F;
    mem[1] = 128'hF0;
    start_frame(2);
    wait_done(2);
    chk("csum_ff", csum, 128'hFF);
    fill_random(3);
    start_frame(3);
    @(negedge clk);
    chk("csum_cleared", csum, '0);
    wait_done(3);
`endif

    // Recovery after reset
    ready_mode = 1;
    fill_random(5);
    start_frame(5);
    wait_done(5);

    repeat (5) @(negedge clk);
    chk("frames_done", done_seen, frames_exp);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
